// File: rtl/frv_mem_arbiter.sv
// Shares one downstream memory port between the imem and dmem requesters and
// routes in-order responses back to the owner of each transaction.
module frv_mem_arbiter #(
  parameter int unsigned OUTSTANDING   = 2,
  parameter bit          DMEM_PRIORITY = 1'b0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        i_req,
  input  logic        i_wen,
  input  logic [3:0]  i_strb,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_recv,
  input  logic        i_ack,
  output logic        i_error,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [3:0]  d_strb,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_recv,
  input  logic        d_ack,
  output logic        d_error,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_wen,
  output logic [3:0]  m_strb,
  output logic [31:0] m_wdata,
  output logic [31:0] m_addr,
  input  logic        m_gnt,
  input  logic        m_recv,
  output logic        m_ack,
  input  logic        m_error,
  input  logic [31:0] m_rdata
);

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } owner_e;

  logic [OUTSTANDING-1:0] id_q, id_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  owner_e                 last_q, last_d;
  owner_e                 lock_sel_q, lock_sel_d;
  logic                   lock_q, lock_d;

  logic   fifo_empty;
  logic   fifo_full;
  logic   sel_valid;
  owner_e sel;
  owner_e head;
  logic   push;
  logic   pop;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign head       = owner_e'(id_q[rd_ptr_q]);

  // Selection is frozen while a downstream offer is waiting for m_gnt.
  always_comb begin
    sel_valid = 1'b0;
    sel       = OWN_IMEM;
    if (lock_q) begin
      sel_valid = 1'b1;
      sel       = lock_sel_q;
    end else if (i_req && d_req) begin
      sel_valid = 1'b1;
      if (DMEM_PRIORITY) begin
        sel = OWN_DMEM;
      end else begin
        sel = (last_q == OWN_IMEM) ? OWN_DMEM : OWN_IMEM;
      end
    end else if (d_req) begin
      sel_valid = 1'b1;
      sel       = OWN_DMEM;
    end else if (i_req) begin
      sel_valid = 1'b1;
      sel       = OWN_IMEM;
    end
  end

  // Request path and response routing, all combinational.
  always_comb begin
    m_req   = 1'b0;
    m_wen   = 1'b0;
    m_strb  = '0;
    m_wdata = '0;
    m_addr  = '0;
    if (sel_valid) begin
      if (sel == OWN_DMEM) begin
        m_req   = d_req;
        m_wen   = d_wen;
        m_strb  = d_strb;
        m_wdata = d_wdata;
        m_addr  = d_addr;
      end else begin
        m_req   = i_req;
        m_wen   = i_wen;
        m_strb  = i_strb;
        m_wdata = i_wdata;
        m_addr  = i_addr;
      end
    end
    m_req = m_req && !fifo_full && g_resetn;

    i_gnt = m_req && m_gnt && (sel == OWN_IMEM);
    d_gnt = m_req && m_gnt && (sel == OWN_DMEM);

    i_recv  = m_recv && !fifo_empty && (head == OWN_IMEM);
    d_recv  = m_recv && !fifo_empty && (head == OWN_DMEM);
    m_ack   = !fifo_empty && ((head == OWN_DMEM) ? d_ack : i_ack);
    i_rdata = m_rdata;
    d_rdata = m_rdata;
    i_error = m_error;
    d_error = m_error;
  end

  assign push = m_req && m_gnt;
  assign pop  = m_recv && m_ack;

  // Owner FIFO, round-robin history and lock next-state.
  always_comb begin
    id_d       = id_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_d     = last_q;
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    if (push) begin
      id_d[wr_ptr_q] = sel;
      wr_ptr_d       = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      last_d         = sel;
      lock_d         = 1'b0;
    end else if (m_req) begin
      lock_d     = 1'b1;
      lock_sel_d = sel;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      id_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      last_q     <= OWN_IMEM;
      lock_q     <= 1'b0;
      lock_sel_q <= OWN_IMEM;
    end else begin
      id_q       <= id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  // A response with nothing outstanding is a downstream protocol violation.
  a_no_orphan_recv: assert property (
    @(posedge g_clk) disable iff (!g_resetn) !(m_recv && fifo_empty)
  );

endmodule
